// File: rtl/stdp_depress_ctrl_if.sv
// Request/response bus between the depression controller and its registered dt lookup table.
interface stdp_depress_ctrl_if #(
   parameter int unsigned WW = 24
);
   logic [7:0]    lut_addr;
   logic [WW-1:0] lut_data;

   modport master (output lut_addr, input  lut_data);
   modport slave  (input  lut_addr, output lut_data);
endinterface

// File: rtl/stdp_depress_ctrl.sv
// STDP depression controller: times post->pre interval, looks up the depression
// magnitude and subtracts it from the synaptic weight, saturating at zero.
module stdp_depress_ctrl #(
   parameter int unsigned WW     = 24,
   parameter int unsigned DT_MIN = 2,
   parameter int unsigned DT_MAX = 20
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  tick,
   input  logic                  post_spike,
   input  logic                  pre_spike,
   input  logic                  w_load,
   input  logic [WW-1:0]         w_in,
   stdp_depress_ctrl_if.master   lut,
   output logic [WW-1:0]         weight,
   output logic                  busy,
   output logic                  upd_done,
   output logic [7:0]            drop_cnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      CAP  = 2'd2
   } state_t;

   state_t        state, state_nxt;
   logic [7:0]    age, age_nxt;
   logic          post_seen, post_seen_nxt;
   logic [WW-1:0] weight_nxt;
   logic [7:0]    lut_addr_nxt;
   logic          busy_nxt;
   logic          upd_done_nxt;
   logic [7:0]    drop_cnt_nxt;
   logic          in_window_c;
   logic          launch_c;

   assign in_window_c = (age >= 8'(DT_MIN)) && (age <= 8'(DT_MAX));
   assign launch_c    = pre_spike && post_seen && !post_spike && in_window_c;

   // State and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         age          <= '0;
         post_seen    <= 1'b0;
         weight       <= '0;
         lut.lut_addr <= '0;
         busy         <= 1'b0;
         upd_done     <= 1'b0;
         drop_cnt     <= '0;
      end else begin
         state        <= state_nxt;
         age          <= age_nxt;
         post_seen    <= post_seen_nxt;
         weight       <= weight_nxt;
         lut.lut_addr <= lut_addr_nxt;
         busy         <= busy_nxt;
         upd_done     <= upd_done_nxt;
         drop_cnt     <= drop_cnt_nxt;
      end
   end

   // Next-state and output logic
   always_comb begin
      state_nxt     = state;
      age_nxt       = age;
      post_seen_nxt = post_seen;
      weight_nxt    = weight;
      lut_addr_nxt  = lut.lut_addr;
      upd_done_nxt  = 1'b0;
      drop_cnt_nxt  = drop_cnt;

      // Age tracking runs independently of the update FSM
      if (post_spike) begin
         age_nxt       = '0;
         post_seen_nxt = 1'b1;
      end else if (tick && (age != 8'hFF)) begin
         age_nxt = age + 8'd1;
      end

      if (w_load) begin
         weight_nxt = w_in;
         state_nxt  = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (launch_c) begin
                  lut_addr_nxt = age;
                  state_nxt    = REQ;
               end
            end
            REQ: begin
               if (pre_spike && (drop_cnt != 8'hFF)) drop_cnt_nxt = drop_cnt + 8'd1;
               state_nxt = CAP;
            end
            CAP: begin
               if (pre_spike && (drop_cnt != 8'hFF)) drop_cnt_nxt = drop_cnt + 8'd1;
               weight_nxt   = (weight >= lut.lut_data) ? (weight - lut.lut_data) : '0;
               upd_done_nxt = 1'b1;
               state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end

      busy_nxt = (state_nxt != IDLE);
   end

endmodule

// File: tb/tb_stdp_depress_ctrl.sv
// Directed bench for stdp_depress_ctrl with a registered depression LUT model.
module tb_stdp_depress_ctrl;

   localparam int unsigned WW = 24;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          tick = 1'b0;
   logic          post_spike = 1'b0;
   logic          pre_spike = 1'b0;
   logic          w_load = 1'b0;
   logic [WW-1:0] w_in = '0;
   logic [WW-1:0] weight;
   logic          busy;
   logic          upd_done;
   logic [7:0]    drop_cnt;

   int total = 0;
   int bad   = 0;

   stdp_depress_ctrl_if #(.WW(WW)) lut_if ();

   stdp_depress_ctrl #(.WW(WW), .DT_MIN(2), .DT_MAX(20)) dut (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick),
      .post_spike (post_spike),
      .pre_spike  (pre_spike),
      .w_load     (w_load),
      .w_in       (w_in),
      .lut        (lut_if.master),
      .weight     (weight),
      .busy       (busy),
      .upd_done   (upd_done),
      .drop_cnt   (drop_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [WW-1:0] lut_val(input logic [7:0] dt);
      case (dt)
         8'd2:    lut_val = 24'd329;
         8'd5:    lut_val = 24'd180;
         8'd20:   lut_val = 24'd9;
         default: lut_val = 24'd50;
      endcase
   endfunction

   // Registered lookup table: one-cycle latency
   always_ff @(posedge clk) lut_if.lut_data <= lut_val(lut_if.lut_addr);

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic do_load(input logic [WW-1:0] w);
      w_load = 1'b1; w_in = w;
      cyc();
      w_load = 1'b0;
   endtask

   task automatic do_post();
      post_spike = 1'b1;
      cyc();
      post_spike = 1'b0;
   endtask

   task automatic do_ticks(input int n);
      tick = 1'b1;
      repeat (n) cyc();
      tick = 1'b0;
   endtask

   task automatic do_pre();
      pre_spike = 1'b1;
      cyc();
      pre_spike = 1'b0;
   endtask

   // Pre spike that must launch: check address, latency and the final weight
   task automatic run_upd(input string tag, input logic [7:0] addr, input logic [WW-1:0] w_exp);
      do_pre();
      chk({tag, "_addr"}, 32'(lut_if.lut_addr), 32'(addr));
      chk({tag, "_busy0"}, 32'(busy), 32'd1);
      cyc();
      chk({tag, "_busy1"}, 32'(busy), 32'd1);
      chk({tag, "_upd_early"}, 32'(upd_done), 32'd0);
      cyc();
      chk({tag, "_weight"}, 32'(weight), 32'(w_exp));
      chk({tag, "_upd"}, 32'(upd_done), 32'd1);
      chk({tag, "_busy2"}, 32'(busy), 32'd0);
      cyc();
      chk({tag, "_upd_pulse"}, 32'(upd_done), 32'd0);
   endtask

   // Pre spike that must be ignored
   task automatic no_upd(input string tag, input logic [WW-1:0] w_exp);
      do_pre();
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      cyc();
      cyc();
      chk({tag, "_busy_late"}, 32'(busy), 32'd0);
      chk({tag, "_upd"}, 32'(upd_done), 32'd0);
      chk({tag, "_weight"}, 32'(weight), 32'(w_exp));
   endtask

   initial begin
      // Reset state
      repeat (2) cyc();
      chk("rst_weight", 32'(weight), 32'd0);
      chk("rst_addr", 32'(lut_if.lut_addr), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_drop", 32'(drop_cnt), 32'd0);
      rst = 1'b1;
      cyc();

      // No post spike seen since reset
      do_load(24'd1000);
      chk("load_weight", 32'(weight), 32'd1000);
      no_upd("nopost", 24'd1000);

      // Basic depression
      do_post();
      do_ticks(5);
      run_upd("basic", 8'd5, 24'd820);

      // Window edges
      do_load(24'd1000);
      do_post();
      do_ticks(1);
      no_upd("age1", 24'd1000);
      do_ticks(20);
      no_upd("age21", 24'd1000);
      do_post();
      do_ticks(2);
      run_upd("age2", 8'd2, 24'd671);
      do_load(24'd1000);
      do_post();
      do_ticks(20);
      run_upd("age20", 8'd20, 24'd991);

      // Saturation at zero
      do_load(24'd100);
      do_post();
      do_ticks(2);
      run_upd("sat", 8'd2, 24'd0);

      // Simultaneous pre/post: ignored, age restarts at 0
      do_load(24'd700);
      do_ticks(3);
      pre_spike = 1'b1; post_spike = 1'b1;
      cyc();
      pre_spike = 1'b0; post_spike = 1'b0;
      chk("simul_busy", 32'(busy), 32'd0);
      cyc();
      chk("simul_weight", 32'(weight), 32'd700);
      do_ticks(2);
      run_upd("simul_after", 8'd2, 24'd371);

      // Busy drops: pre held at E0, E1, E2
      do_load(24'd1000);
      do_post();
      do_ticks(5);
      pre_spike = 1'b1;
      repeat (3) cyc();
      pre_spike = 1'b0;
      chk("drop_weight", 32'(weight), 32'd820);
      chk("drop_upd", 32'(upd_done), 32'd1);
      chk("drop_cnt2", 32'(drop_cnt), 32'd2);
      // 450 more cycles of pre: two drops per three-cycle update
      pre_spike = 1'b1;
      repeat (450) cyc();
      pre_spike = 1'b0;
      cyc();
      chk("drop_sat", 32'(drop_cnt), 32'd255);
      cyc();
      cyc();

      // w_load during REQ aborts the update
      do_load(24'd1000);
      do_pre();
      chk("abort_busy_req", 32'(busy), 32'd1);
      w_load = 1'b1; w_in = 24'd500;
      cyc();
      w_load = 1'b0;
      chk("abort_weight", 32'(weight), 32'd500);
      chk("abort_busy", 32'(busy), 32'd0);
      cyc();
      chk("abort_upd", 32'(upd_done), 32'd0);
      chk("abort_weight2", 32'(weight), 32'd500);
      cyc();
      chk("abort_upd2", 32'(upd_done), 32'd0);

      // Reset asserted during CAP
      do_load(24'd1000);
      do_pre();
      cyc();
      chk("rcap_busy", 32'(busy), 32'd1);
      rst = 1'b0;
      #1;
      chk("rcap_weight", 32'(weight), 32'd0);
      chk("rcap_addr", 32'(lut_if.lut_addr), 32'd0);
      chk("rcap_busy0", 32'(busy), 32'd0);
      chk("rcap_drop", 32'(drop_cnt), 32'd0);
      cyc();
      chk("rcap_upd", 32'(upd_done), 32'd0);
      chk("rcap_weight2", 32'(weight), 32'd0);
      rst = 1'b1;
      cyc();

      // post_seen cleared by reset
      do_load(24'd1000);
      do_ticks(5);
      no_upd("rst_nopost", 24'd1000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
